// File: rtl/fb_pkg.sv
// Shared types and framebuffer geometry for the framebuffer arbiter.
package fb_pkg;
    localparam int FB_W     = 200;
    localparam int FB_H     = 600;
    localparam int FB_WORDS = FB_W * FB_H;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU} owner_t;
    typedef enum logic {IDLE, RD_WAIT} cpu_state_t;

    // Read tag carried alongside each RAM cycle; oor marks a CPU read that never touched RAM.
    typedef struct packed {
        logic   valid;
        owner_t owner;
        logic   oor;
    } rtag_t;
endpackage

// File: rtl/fb_wbuf.sv
// Small synchronous FIFO holding buffered CPU writes as {addr,data}.
module fb_wbuf #(
    parameter int DEPTH = 4,
    parameter int W     = 41
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    import fb_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, rd_q;
    logic         do_push, do_pop;

    // Extra pointer bit tells full from empty when the indices coincide.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer RAM arbiter: video reads win every slot, CPU gets the rest.
// Define FB_WBUF_EN to buffer CPU writes in a WBUF_DEPTH-entry FIFO.
module fb_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 24,
    parameter int FB_WORDS   = 120000,
    parameter int WBUF_DEPTH = 4
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_rvalid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    import fb_pkg::*;

    if (WBUF_DEPTH < 2 || (WBUF_DEPTH & (WBUF_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("fb_arbiter: WBUF_DEPTH must be a power of 2 and at least 2");
    end

    localparam logic [ADDR_W:0] WORDS_X = (ADDR_W+1)'(FB_WORDS);

    cpu_state_t        state_q, state_d;
    rtag_t [3:1]       tag_q;
    rtag_t             tag_d;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              err_q;

    logic cpu_oor, rd_ready, wr_ready, cpu_acc, rd_acc, cpu_slot, cpu_done;

    assign cpu_oor  = {1'b0, cpu_addr} >= WORDS_X;
    assign cpu_acc  = cpu_req && cpu_ready;
    assign rd_acc   = cpu_acc && !cpu_we;
    assign cpu_done = tag_q[3].valid && (tag_q[3].owner == OWN_CPU);

`ifdef FB_WBUF_EN
    logic                     wb_push, wb_pop, wb_full, wb_empty;
    logic [ADDR_W+DATA_W-1:0] wb_rdata;

    // Reads wait for an empty buffer so they never overtake a pending write.
    assign rd_ready = (state_q == IDLE) && !vid_req && wb_empty && !RESET;
    assign wr_ready = !wb_full && !RESET;
    assign wb_push  = cpu_acc && cpu_we && !cpu_oor;
    assign wb_pop   = !vid_req && !wb_empty;
    assign cpu_slot = rd_acc && !cpu_oor;

    fb_wbuf #(.DEPTH(WBUF_DEPTH), .W(ADDR_W + DATA_W)) u_wbuf (
        .clk_i   (CLOCK_50),
        .rst_i   (RESET),
        .push_i  (wb_push),
        .pop_i   (wb_pop),
        .wdata_i ({cpu_addr, cpu_wdata}),
        .rdata_o (wb_rdata),
        .full_o  (wb_full),
        .empty_o (wb_empty)
    );
`else
    assign rd_ready = (state_q == IDLE) && !vid_req && !RESET;
    assign wr_ready = rd_ready;
    assign cpu_slot = cpu_acc && !cpu_oor;
`endif

    assign cpu_ready = cpu_we ? wr_ready : rd_ready;

    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        tag_d       = '0;
        if (vid_req) begin
            ram_addr_d  = vid_addr;
            tag_d.valid = 1'b1;
            tag_d.owner = OWN_VID;
`ifdef FB_WBUF_EN
        end else if (wb_pop) begin
            {ram_addr_d, ram_wdata_d} = wb_rdata;
            ram_we_d = 1'b1;
`endif
        end else if (cpu_slot) begin
            ram_addr_d = cpu_addr;
            ram_we_d   = cpu_we;
            if (cpu_we) ram_wdata_d = cpu_wdata;
        end
        // Out-of-range reads still ride the pipeline so the response keeps its latency.
        if (rd_acc) begin
            tag_d.valid = 1'b1;
            tag_d.owner = OWN_CPU;
            tag_d.oor   = cpu_oor;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rd_acc)   state_d = RD_WAIT;
            RD_WAIT: if (cpu_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            tag_q       <= '0;
            rdata_q     <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tag_q[1]    <= tag_d;
            tag_q[2]    <= tag_q[1];
            tag_q[3]    <= tag_q[2];
            rdata_q     <= ram_rdata;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            err_q       <= cpu_acc && cpu_oor;
        end
    end

    assign vid_rvalid = tag_q[3].valid && (tag_q[3].owner == OWN_VID);
    assign vid_rdata  = vid_rvalid ? rdata_q : '0;
    assign cpu_rvalid = cpu_done;
    assign cpu_rdata  = (cpu_done && !tag_q[3].oor) ? rdata_q : '0;
    assign cpu_err    = err_q;
    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_wdata  = ram_wdata_q;
endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: directed sequences, vector table, and a
// randomized run against a cycle-time scoreboard with a behavioural RAM.
module tb_fb_arbiter;
    localparam int WORDS = 120000;

    logic        CLOCK_50 = 1'b0;
    logic        RESET = 1'b1;
    logic        vid_req = 1'b0;
    logic [16:0] vid_addr = '0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [16:0] cpu_addr = '0;
    logic [23:0] cpu_wdata = '0;
    logic [23:0] vid_rdata, cpu_rdata, ram_wdata, ram_rdata;
    logic        vid_rvalid, cpu_ready, cpu_rvalid, cpu_err, ram_we;
    logic [16:0] ram_addr;

    fb_arbiter dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_err(cpu_err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic logic [23:0] pat(input int a);
        if (a == 5) return 24'hFF00AA;
        return 24'(a * 40503) ^ 24'h5A5A5A;
    endfunction

    // Single-port RAM with one-cycle read latency.
    logic [23:0] ram [0:131071];
    logic [23:0] mdl [0:131071];
    initial for (int i = 0; i < 131072; i++) ram[i] <= pat(i);
    initial for (int i = 0; i < 131072; i++) mdl[i] = pat(i);
    always @(posedge CLOCK_50) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    int n_chk = 0, n_fail = 0, cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every accepted request schedules its consequences by cycle number.
    typedef struct {int due; logic [23:0] data;} rsp_t;
    typedef struct {int due; logic we; logic [16:0] addr; logic [23:0] data;} slot_t;
    rsp_t  vq[$], cq[$];
    slot_t sq[$];
    int    eq[$];
    int    busy_until = -1;
    logic  ev, ec, ee, es, oor_m;

    always @(negedge CLOCK_50) begin
        cyc++;
        if (RESET) begin
            check("rst_vid_rvalid", vid_rvalid, 0);
            check("rst_vid_rdata", vid_rdata, 0);
            check("rst_cpu_rvalid", cpu_rvalid, 0);
            check("rst_cpu_rdata", cpu_rdata, 0);
            check("rst_cpu_err", cpu_err, 0);
            check("rst_cpu_ready", cpu_ready, 0);
            check("rst_ram_we", ram_we, 0);
            check("rst_ram_addr", ram_addr, 0);
            check("rst_ram_wdata", ram_wdata, 0);
            vq.delete(); cq.delete(); sq.delete(); eq.delete();
            busy_until = -1;
        end else begin
            ev = vq.size() > 0 && vq[0].due == cyc;
            check("vid_rvalid", vid_rvalid, ev);
            if (ev) begin check("vid_rdata", vid_rdata, vq[0].data); void'(vq.pop_front()); end
            ec = cq.size() > 0 && cq[0].due == cyc;
            check("cpu_rvalid", cpu_rvalid, ec);
            if (ec) begin check("cpu_rdata", cpu_rdata, cq[0].data); void'(cq.pop_front()); end
            ee = eq.size() > 0 && eq[0] == cyc;
            check("cpu_err", cpu_err, ee);
            if (ee) void'(eq.pop_front());
`ifndef FB_WBUF_EN
            es = sq.size() > 0 && sq[0].due == cyc;
            check("ram_we", ram_we, es ? sq[0].we : 1'b0);
            if (es) begin
                check("ram_addr", ram_addr, sq[0].addr);
                if (sq[0].we) check("ram_wdata", ram_wdata, sq[0].data);
                void'(sq.pop_front());
            end
            check("cpu_ready", cpu_ready, !vid_req && cyc > busy_until);
`else
            if (!cpu_we && (vid_req || cyc <= busy_until)) check("cpu_ready_rd_blocked", cpu_ready, 0);
`endif
            if (ram_we) check("ram_we_in_range", ram_addr < 17'(WORDS), 1);
            if (vid_req) begin
                vq.push_back('{cyc + 3, mdl[vid_addr]});
                sq.push_back('{cyc + 1, 1'b0, vid_addr, 24'h0});
            end
            if (cpu_req && cpu_ready) begin
                oor_m = cpu_addr >= 17'(WORDS);
                if (oor_m) eq.push_back(cyc + 1);
                if (cpu_we) begin
                    if (!oor_m) begin
                        mdl[cpu_addr] = cpu_wdata;
                        sq.push_back('{cyc + 1, 1'b1, cpu_addr, cpu_wdata});
                    end
                end else begin
                    cq.push_back('{cyc + 3, oor_m ? 24'h0 : mdl[cpu_addr]});
                    busy_until = cyc + 3;
                    if (!oor_m) sq.push_back('{cyc + 1, 1'b0, cpu_addr, 24'h0});
                end
            end
        end
    end

    task automatic cpu_op(input logic we, input logic [16:0] a, input logic [23:0] wd,
                          output logic err, output logic [23:0] rd, output logic ok);
        int n;
        err = 1'b0; rd = '0; ok = 1'b0;
        @(posedge CLOCK_50); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        n = 0;
        @(negedge CLOCK_50);
        while (!cpu_ready && n < 50) begin @(negedge CLOCK_50); n++; end
        if (!cpu_ready) begin cpu_req = 1'b0; return; end
        @(posedge CLOCK_50); #1;
        cpu_req = 1'b0;
        @(negedge CLOCK_50);
        err = cpu_err;
        if (we) ok = 1'b1;
        else begin
            n = 0;
            while (!cpu_rvalid && n < 10) begin @(negedge CLOCK_50); n++; end
            ok = cpu_rvalid;
            rd = cpu_rdata;
        end
    endtask

    function automatic logic [16:0] pick_addr();
        int r = $urandom_range(0, 15);
        if (r == 0) return 17'd119999;
        if (r < 3) return 17'(120000 + $urandom_range(0, 11071));
        return 17'(1000 + $urandom_range(0, 31));
    endfunction

    typedef struct {logic we; logic [16:0] addr; logic [23:0] wd; logic exp_err; logic [23:0] exp_rd;} vec_t;
    vec_t tbl[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        err, ok, acc_last;
        logic [23:0] rd;
        int          cnt, sent, stalls, racc;

        tbl[0] = '{1'b1, 17'd119999, 24'h123456, 1'b0, 24'h0};
        tbl[1] = '{1'b0, 17'd119999, 24'h0, 1'b0, 24'h123456};
        tbl[2] = '{1'b1, 17'd120000, 24'hABCDEF, 1'b1, 24'h0};
        tbl[3] = '{1'b0, 17'd119999, 24'h0, 1'b0, 24'h123456};
        tbl[4] = '{1'b0, 17'd120000, 24'h0, 1'b1, 24'h0};
        tbl[5] = '{1'b0, 17'h1FFFF, 24'h0, 1'b1, 24'h0};
        tbl[6] = '{1'b1, 17'd300, 24'hFFFFFF, 1'b0, 24'h0};
        tbl[7] = '{1'b0, 17'd300, 24'h0, 1'b0, 24'hFFFFFF};
        tbl[8] = '{1'b0, 17'd0, 24'h0, 1'b0, pat(0)};
        tbl[9] = '{1'b0, 17'd5, 24'h0, 1'b0, 24'hFF00AA};

        // Reset, with a read already waiting: it is taken the first cycle after release.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'd300;
        repeat (3) @(posedge CLOCK_50);
        #1 RESET = 1'b0;
        @(negedge CLOCK_50);
        check("release_ready", cpu_ready, 1);
        @(posedge CLOCK_50); #1 cpu_req = 1'b0;
        repeat (5) @(posedge CLOCK_50);

        // Video latency from addr 5.
        #1 vid_req = 1'b1; vid_addr = 17'd5;
        @(posedge CLOCK_50); #1 vid_req = 1'b0;
        @(negedge CLOCK_50); check("vid_lat_t1", vid_rvalid, 0);
        @(negedge CLOCK_50); check("vid_lat_t2", vid_rvalid, 0);
        @(negedge CLOCK_50); check("vid_lat_t3", vid_rvalid, 1);
        check("vid_lat_data", vid_rdata, 24'hFF00AA);

        // Collision: video wins, CPU read retries and is taken next cycle.
        @(posedge CLOCK_50); #1;
        vid_req = 1'b1; vid_addr = 17'd7;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'd1500;
        @(negedge CLOCK_50); check("coll_ready_t0", cpu_ready, 0);
        @(posedge CLOCK_50); #1 vid_req = 1'b0;
        @(negedge CLOCK_50); check("coll_ready_t1", cpu_ready, 1);
        @(posedge CLOCK_50); #1 cpu_req = 1'b0;
        @(negedge CLOCK_50); check("coll_vid_t2", vid_rvalid, 0);
        @(negedge CLOCK_50); check("coll_vid_t3", vid_rvalid, 1);
        check("coll_vid_data", vid_rdata, pat(7));
        @(negedge CLOCK_50); check("coll_cpu_t4", cpu_rvalid, 1);
        check("coll_cpu_data", cpu_rdata, pat(1500));

        // Vector table of CPU transactions.
        for (int i = 0; i < 10; i++) begin
            cpu_op(tbl[i].we, tbl[i].addr, tbl[i].wd, err, rd, ok);
            check($sformatf("tbl%0d_done", i), ok, 1);
            check($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
            if (!tbl[i].we) check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
        end
        check("oor_ram_untouched", ram[120000], pat(120000));

        // Reset in the middle of a read: the response is discarded.
        @(posedge CLOCK_50); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'd2000;
        @(negedge CLOCK_50); check("rstmid_accept", cpu_ready, 1);
        @(posedge CLOCK_50); #1;
        cpu_req = 1'b0; RESET = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        #1 RESET = 1'b0;
        @(negedge CLOCK_50); check("rstmid_ready", cpu_ready, 1);
        cnt = int'(cpu_rvalid);
        repeat (5) begin @(negedge CLOCK_50); cnt += int'(cpu_rvalid); end
        check("rstmid_no_rvalid", cnt, 0);

`ifdef FB_WBUF_EN
        // Video every other cycle leaves too few drain slots: the buffer fills and stalls.
        sent = 0; stalls = 0;
        for (int c = 0; c < 200 && sent < 10; c++) begin
            @(posedge CLOCK_50); #1;
            vid_req = (c % 2 == 0); vid_addr = 17'(20 + c % 50);
            cpu_req = 1'b1; cpu_we = 1'b1;
            cpu_addr = 17'(3000 + sent); cpu_wdata = 24'(24'h100000 + sent);
            @(negedge CLOCK_50);
            if (cpu_ready) sent++; else stalls++;
        end
        @(posedge CLOCK_50); #1 cpu_req = 1'b0; vid_req = 1'b0;
        check("wb_all_sent", sent, 10);
        check("wb_stalled", stalls > 0, 1);
        cpu_op(1'b0, 17'd3009, 24'h0, err, rd, ok);
        check("wb_read_done", ok, 1);
        check("wb_read_data", rd, 24'h100009);
        check("wb_ram_first", ram[3000], 24'h100000);
        check("wb_ram_last", ram[3009], 24'h100009);
`endif

        // Random CPU traffic while video pulses every 5 cycles over two lines.
        acc_last = 1'b0; racc = 0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge CLOCK_50); #1;
            if (acc_last) cpu_req = 1'b0;
            vid_req = (c % 5 == 0);
            vid_addr = 17'((c / 5) % 400);
            if (!cpu_req && $urandom_range(0, 1) == 1) begin
                cpu_req = 1'b1;
                cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = pick_addr();
                cpu_wdata = 24'($urandom);
            end
            @(negedge CLOCK_50);
            acc_last = cpu_req && cpu_ready;
            if (acc_last) racc++;
        end
        @(posedge CLOCK_50); #1 cpu_req = 1'b0; vid_req = 1'b0;
        repeat (10) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("rand_accepts", racc > 200, 1);
        check("vid_queue_drained", vq.size(), 0);
        check("cpu_queue_drained", cq.size(), 0);
        check("err_queue_drained", eq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
